// File: rtl/final_fifo_link_tx.sv
// final_fifo_link_tx
// Transmit end of the inter-FPGA final-FIFO link. Each accepted message is sent
// as one header flit carrying local status, followed by FLITS payload slices
// (LSB first, zero padded). When no message is pending and the local status
// differs from what was last sent, a single status flit goes out instead.
// Flow control is credit based against the receiver's message buffer.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   msg_in_data/valid   message from the local final FIFO
//   msg_in_ready        message accepted on valid && ready at posedge
//   has_message_flying  local status bit (flit bit 0)
//   has_odd_clusters    local status bit (flit bit 1)
//   link_data/valid     registered flit to the other FPGA, no backpressure
//   credit_return       one-cycle pulse per message freed by the receiver
//   busy                state machine is not idle
//   credit_error        sticky: credit returned while the counter was full
module final_fifo_link_tx #(
  parameter int unsigned MSG_WIDTH  = 17,
  parameter int unsigned LINK_WIDTH = 8,
  parameter int unsigned CREDITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MSG_WIDTH-1:0]  msg_in_data,
  input  logic                  msg_in_valid,
  output logic                  msg_in_ready,
  input  logic                  has_message_flying,
  input  logic                  has_odd_clusters,
  output logic [LINK_WIDTH-1:0] link_data,
  output logic                  link_valid,
  input  logic                  credit_return,
  output logic                  busy,
  output logic                  credit_error
);

  localparam int unsigned FLITS  = (MSG_WIDTH + LINK_WIDTH - 1) / LINK_WIDTH;
  localparam int unsigned SHW    = FLITS * LINK_WIDTH;
  localparam int unsigned BEAT_W = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam int unsigned CRED_W = $clog2(CREDITS + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FLITS - 1);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(CREDITS);

  localparam logic [1:0] TYPE_HDR    = 2'b10;
  localparam logic [1:0] TYPE_STATUS = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StPayload,
    StStatus
  } state_e;

  state_e                  state_q, state_d;
  logic [LINK_WIDTH-1:0]   link_data_q, link_data_d;
  logic                    link_valid_q, link_valid_d;
  logic [SHW-1:0]          shreg_q, shreg_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [CRED_W-1:0]       credits_q, credits_d;
  logic [1:0]              last_status_q, last_status_d;
  logic [1:0]              pend_status_q, pend_status_d;
  logic                    credit_error_q, credit_error_d;

  logic [1:0] status;
  logic       handshake;

  // Control flit: type in the top two bits, status in bits [1:0], rest zero.
  function automatic logic [LINK_WIDTH-1:0] make_flit(input logic [1:0] ftype,
                                                      input logic [1:0] st);
    logic [LINK_WIDTH-1:0] f;
    f = '0;
    f[LINK_WIDTH-1 -: 2] = ftype;
    f[1:0] = st;
    return f;
  endfunction

  assign status    = {has_odd_clusters, has_message_flying};
  // Ready is gated by reset so nothing can be accepted while reset is held.
  assign msg_in_ready = !reset && (state_q == StIdle) && (credits_q != '0);
  assign handshake    = msg_in_valid && msg_in_ready;
  assign busy         = (state_q != StIdle);

  assign link_data    = link_data_q;
  assign link_valid   = link_valid_q;
  assign credit_error = credit_error_q;

  // Flit sequencing. Link outputs are loaded on the edge that leaves each
  // state, so the header is visible the cycle after the handshake and the
  // status flit the cycle after STATUS is occupied.
  always_comb begin
    state_d       = state_q;
    link_data_d   = '0;
    link_valid_d  = 1'b0;
    shreg_d       = shreg_q;
    beat_d        = beat_q;
    last_status_d = last_status_q;
    pend_status_d = pend_status_q;

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          // A message wins over a status change; the header carries it.
          shreg_d       = SHW'(msg_in_data);
          link_data_d   = make_flit(TYPE_HDR, status);
          link_valid_d  = 1'b1;
          last_status_d = status;
          state_d       = StHdr;
        end else if (status != last_status_q) begin
          // Capture now so changes while busy cannot alter this flit.
          pend_status_d = status;
          state_d       = StStatus;
        end
      end
      StHdr: begin
        link_data_d  = shreg_q[LINK_WIDTH-1:0];
        link_valid_d = 1'b1;
        shreg_d      = shreg_q >> LINK_WIDTH;
        beat_d       = '0;
        state_d      = StPayload;
      end
      StPayload: begin
        if (beat_q == LAST_BEAT) begin
          state_d = StIdle;
        end else begin
          link_data_d  = shreg_q[LINK_WIDTH-1:0];
          link_valid_d = 1'b1;
          shreg_d      = shreg_q >> LINK_WIDTH;
          beat_d       = beat_q + BEAT_W'(1);
        end
      end
      StStatus: begin
        link_data_d   = make_flit(TYPE_STATUS, pend_status_q);
        link_valid_d  = 1'b1;
        last_status_d = pend_status_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Credit accounting. A simultaneous take and return cancel out; a return
  // with the counter already full saturates and flags a protocol error.
  always_comb begin
    credits_d      = credits_q;
    credit_error_d = credit_error_q;

    if (credit_return && (credits_q == CRED_MAX)) begin
      credit_error_d = 1'b1;
    end

    case ({handshake, credit_return})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   if (credits_q != CRED_MAX) credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      link_data_q    <= '0;
      link_valid_q   <= 1'b0;
      shreg_q        <= '0;
      beat_q         <= '0;
      credits_q      <= CRED_MAX;
      last_status_q  <= 2'b00;
      pend_status_q  <= 2'b00;
      credit_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      link_data_q    <= link_data_d;
      link_valid_q   <= link_valid_d;
      shreg_q        <= shreg_d;
      beat_q         <= beat_d;
      credits_q      <= credits_d;
      last_status_q  <= last_status_d;
      pend_status_q  <= pend_status_d;
      credit_error_q <= credit_error_d;
    end
  end

endmodule

// File: tb/tb_final_fifo_link_tx.sv
// Scoreboard bench: stimulus pushes expected flits, a monitor pops and
// compares every valid link flit. Timing and credit behaviour are checked
// directly from the stimulus side.
module tb_final_fifo_link_tx;

  localparam int unsigned MSG_WIDTH  = 17;
  localparam int unsigned LINK_WIDTH = 8;
  localparam int unsigned CREDITS    = 4;

  logic                  clk;
  logic                  reset;
  logic [MSG_WIDTH-1:0]  msg_in_data;
  logic                  msg_in_valid;
  logic                  msg_in_ready;
  logic                  has_message_flying;
  logic                  has_odd_clusters;
  logic [LINK_WIDTH-1:0] link_data;
  logic                  link_valid;
  logic                  credit_return;
  logic                  busy;
  logic                  credit_error;

  final_fifo_link_tx #(
    .MSG_WIDTH (MSG_WIDTH),
    .LINK_WIDTH(LINK_WIDTH),
    .CREDITS   (CREDITS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .msg_in_data       (msg_in_data),
    .msg_in_valid      (msg_in_valid),
    .msg_in_ready      (msg_in_ready),
    .has_message_flying(has_message_flying),
    .has_odd_clusters  (has_odd_clusters),
    .link_data         (link_data),
    .link_valid        (link_valid),
    .credit_return     (credit_return),
    .busy              (busy),
    .credit_error      (credit_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int seq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected flits for one message: header then three LSB-first slices.
  task automatic push_msg(input logic [16:0] d, input logic [1:0] st);
    logic [23:0] pad;
    pad = {7'b0, d};
    exp_q.push_back({2'b10, 4'b0000, st});
    exp_q.push_back(pad[7:0]);
    exp_q.push_back(pad[15:8]);
    exp_q.push_back(pad[23:16]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_return();
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
  endtask

  // Monitor: every valid flit must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && link_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flit: got %02h, none expected (t=%0t)", link_data, $time);
        end else begin
          check("flit", {24'h0, link_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Present one message and wait (bounded) for its handshake.
  task automatic send_one(input logic [16:0] d, output int hs_cyc);
    bit done;
    done = 0;
    hs_cyc = -1;
    msg_in_data  = d;
    msg_in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (msg_in_ready) begin
        push_msg(d, {has_odd_clusters, has_message_flying});
        hs_cyc = cyc;
        done = 1;
      end
      tick();
    end
    msg_in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no handshake, expected one for %05h", d);
    end
  endtask

  // Hold valid for a cycle budget, feeding fresh data after each handshake.
  task automatic stream(input int budget, input bit chk_period, output int got);
    int last;
    logic [16:0] d;
    got = 0;
    last = 0;
    d = 17'h0A000 ^ 17'(seq * 17'h0313);
    msg_in_data  = d;
    msg_in_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (msg_in_ready) begin
        push_msg(d, {has_odd_clusters, has_message_flying});
        if (chk_period && got > 0) check("b2b_period", 32'(cyc - last), 32'd5);
        last = cyc;
        got++;
        seq++;
        tick();
        d = 17'h0A000 ^ 17'(seq * 17'h0313);
        msg_in_data = d;
      end else begin
        tick();
      end
    end
    msg_in_valid = 1'b0;
  endtask

  int hs;
  int got;

  initial begin
    reset = 1'b1;
    msg_in_data = '0;
    msg_in_valid = 1'b0;
    has_message_flying = 1'b0;
    has_odd_clusters = 1'b0;
    credit_return = 1'b0;

    // Reset values
    #7;
    check("rst_link_valid", {31'h0, link_valid}, 32'd0);
    check("rst_link_data", {24'h0, link_data}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_credit_error", {31'h0, credit_error}, 32'd0);
    check("rst_ready_low", {31'h0, msg_in_ready}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'h0, msg_in_ready}, 32'd1);

    // Status-only flit: flying 0->1 at cycle M gives 8'h41 at M+2
    @(posedge clk);
    #1;
    has_message_flying = 1'b1;
    exp_q.push_back(8'h41);
    @(negedge clk);
    check("status_m0_valid", {31'h0, link_valid}, 32'd0);
    @(negedge clk);
    check("status_m1_busy", {31'h0, busy}, 32'd1);
    check("status_m1_valid", {31'h0, link_valid}, 32'd0);
    @(negedge clk);
    check("status_m2_valid", {31'h0, link_valid}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("status_stable_quiet", {31'h0, link_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    has_message_flying = 1'b0;
    exp_q.push_back(8'h40);
    repeat (4) tick();

    // Single message; odd goes high in the handshake cycle (priority case)
    has_odd_clusters = 1'b1;
    send_one(17'h1A5C3, hs);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("msg_valid_window", {31'h0, link_valid}, 32'd1);
      check("msg_busy_window", {31'h0, busy}, 32'd1);
    end
    @(negedge clk);
    check("msg_gap_valid", {31'h0, link_valid}, 32'd0);
    check("msg_ready_again", {31'h0, msg_in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_status_after_priority", {31'h0, link_valid}, 32'd0);
    end
    tick();

    // Restore to full credits, then back-to-back until exhausted
    pulse_return();
    check("no_error_at_full", {31'h0, credit_error}, 32'd0);
    stream(40, 1'b1, got);
    check("exhaust_count", 32'(got), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("exhaust_ready_low", {31'h0, msg_in_ready}, 32'd0);
    end
    tick();
    pulse_return();
    stream(20, 1'b0, got);
    check("one_more_count", 32'(got), 32'd1);

    // Handshake and credit_return together: credits stay at 1
    pulse_return();
    msg_in_data = 17'h15A5A;
    msg_in_valid = 1'b1;
    credit_return = 1'b1;
    @(negedge clk);
    check("simul_ready", {31'h0, msg_in_ready}, 32'd1);
    if (msg_in_ready) push_msg(17'h15A5A, {has_odd_clusters, has_message_flying});
    tick();
    msg_in_valid = 1'b0;
    credit_return = 1'b0;
    stream(20, 1'b0, got);
    check("after_simul_count", 32'(got), 32'd1);
    @(negedge clk);
    check("simul_exhausted", {31'h0, msg_in_ready}, 32'd0);
    tick();

    // Saturation and sticky credit_error
    repeat (4) pulse_return();
    @(negedge clk);
    check("full_no_error", {31'h0, credit_error}, 32'd0);
    tick();
    pulse_return();
    @(negedge clk);
    check("overflow_error", {31'h0, credit_error}, 32'd1);
    tick();
    stream(30, 1'b1, got);
    check("saturated_count", 32'(got), 32'd4);
    check("error_sticky", {31'h0, credit_error}, 32'd1);

    // Reset during payload beat 1
    has_odd_clusters = 1'b0;
    exp_q.push_back(8'h40);
    repeat (4) tick();
    pulse_return();
    send_one(17'h0BEEF, hs);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_link_valid", {31'h0, link_valid}, 32'd0);
    check("async_link_data", {24'h0, link_data}, 32'd0);
    check("async_busy", {31'h0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    check("rst_clears_error", {31'h0, credit_error}, 32'd0);
    stream(30, 1'b1, got);
    check("post_reset_count", 32'(got), 32'd4);

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
